// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage
//   Instruction-fetch stage sitting after the PC-select mux. It holds the
//   architectural PC and keeps at most one instruction-memory request in
//   flight. Each fetched {pc, instr} pair goes to decode through a one-entry
//   valid/ready output register. A redirect always wins: it loads the
//   word-aligned target, flushes the output register, and any response that
//   is still outstanding gets dropped.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   redirect_valid/_pc        load redirect target as next fetch address
//   imem_req_valid/_ready     request handshake; imem_req_addr = fetch address
//   imem_rsp_valid/_data      response channel (no backpressure)
//   if_valid/_ready           output handshake towards decode
//   if_pc, if_instr           presented instruction and its PC
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            free;
  logic            req_fire;

  // A request is only issued while the output slot can take its response,
  // so a response can never overwrite an entry decode has not consumed.
  always_comb begin
    free           = !if_valid_q || if_ready;
    imem_req_valid = !rst && (state_q == S_REQ) && free && !redirect_valid;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    if (if_valid_q && if_ready) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = imem_rsp_data;
          pc_d       = pc_q + XLEN'(4);
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides everything above, including a response landing in
    // the same cycle. If a request is still outstanding and its response has
    // not arrived yet, go to DROP so that response is swallowed when it shows.
    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      if_valid_d = 1'b0;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if ((state_q == S_REQ) || imem_rsp_valid) begin
        state_d = S_REQ;
      end else begin
        state_d = S_DROP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= {RESET_PC[XLEN-1:2], 2'b00};
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int passed = 0;
  int total  = 0;
  bit auto_mem = 1'b1;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  // Memory content: instruction word = address ^ 32'hDEAD_0000.
  // One clock edge. With auto_mem set, a request accepted at this edge
  // is answered with a 1-cycle response during the following cycle.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rsp_valid = hs;
      imem_rsp_data  = hs ? (a ^ 32'hDEAD_0000) : 32'h0;
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if_ready = rdy; auto_mem = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL rst_if_valid: got %b expected 0", if_valid); else passed++;
    total++; if (if_pc !== 32'h0) $display("FAIL rst_if_pc: got %h expected 00000000", if_pc); else passed++;
    total++; if (if_instr !== 32'h0) $display("FAIL rst_if_instr: got %h expected 00000000", if_instr); else passed++;
    rst = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
      $display("FAIL rst_first_req: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr); else passed++;
  endtask

  // Two cycles per instruction: request, response, then the next request
  // in the same cycle the previous instruction is presented.
  task automatic test_stream();
    logic [31:0] a;
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) begin
      a = 32'(k) * 32'd4;
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== a)
        $display("FAIL stream_req%0d: got v=%b a=%h expected v=1 a=%h", k, imem_req_valid, imem_req_addr, a); else passed++;
      tick();
      total++; if (imem_req_valid !== 1'b0) $display("FAIL stream_wait%0d: got req_valid=%b expected 0", k, imem_req_valid); else passed++;
      tick();
      total++; if (if_valid !== 1'b1 || if_pc !== a || if_instr !== (a ^ 32'hDEAD_0000))
        $display("FAIL stream_out%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 k, if_valid, if_pc, if_instr, a, a ^ 32'hDEAD_0000); else passed++;
    end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC)
      $display("FAIL stream_req3: got v=%b a=%h expected v=1 a=0000000c", imem_req_valid, imem_req_addr); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hDEAD_0000 || imem_req_valid !== 1'b0)
        $display("FAIL bp_hold%0d: got v=%b pc=%h instr=%h req=%b expected v=1 pc=00000000 instr=dead0000 req=0",
                 k, if_valid, if_pc, if_instr, imem_req_valid); else passed++;
      tick();
    end
    if_ready = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4)
      $display("FAIL bp_release_req: got v=%b a=%h expected v=1 a=00000004", imem_req_valid, imem_req_addr); else passed++;
    tick();
    total++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0)
      $display("FAIL bp_consumed: got if_valid=%b req=%b expected 0 0", if_valid, imem_req_valid); else passed++;
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'hDEAD_0004)
      $display("FAIL bp_next: got v=%b pc=%h instr=%h expected v=1 pc=00000004 instr=dead0004", if_valid, if_pc, if_instr); else passed++;
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b1);
    auto_mem = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL rw_redirect_cycle: got req=%b expected 0", imem_req_valid); else passed++;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0)
      $display("FAIL rw_drop: got if_valid=%b req=%b expected 0 0", if_valid, imem_req_valid); else passed++;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000)
      $display("FAIL rw_new_req: got if_valid=%b req=%b a=%h expected 0 1 00001000", if_valid, imem_req_valid, imem_req_addr); else passed++;
    auto_mem = 1'b1;
    tick(); tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h1000 || if_instr !== 32'hDEAD_1000)
      $display("FAIL rw_out: got v=%b pc=%h instr=%h expected v=1 pc=00001000 instr=dead1000", if_valid, if_pc, if_instr); else passed++;
  endtask

  task automatic test_redirect_flush();
    do_reset(1'b0);
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL fl_redirect_cycle: got req=%b expected 0", imem_req_valid); else passed++;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40)
      $display("FAIL fl_flushed: got if_valid=%b req=%b a=%h expected 0 1 00000040", if_valid, imem_req_valid, imem_req_addr); else passed++;
  endtask

  task automatic test_redirect_same_cycle();
    do_reset(1'b1);
    auto_mem = 1'b0;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL sc_redirect_cycle: got req=%b expected 0", imem_req_valid); else passed++;
    tick();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000)
      $display("FAIL sc_next_req: got if_valid=%b req=%b a=%h expected 0 1 00002000", if_valid, imem_req_valid, imem_req_addr); else passed++;
    auto_mem = 1'b1;
    tick(); tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h2000 || if_instr !== 32'hDEAD_2000)
      $display("FAIL sc_out: got v=%b pc=%h instr=%h expected v=1 pc=00002000 instr=dead2000", if_valid, if_pc, if_instr); else passed++;
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL wr_redirect_cycle: got req=%b expected 0", imem_req_valid); else passed++;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC)
      $display("FAIL wr_req_top: got v=%b a=%h expected v=1 a=fffffffc", imem_req_valid, imem_req_addr); else passed++;
    tick(); tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h2152_FFFC)
      $display("FAIL wr_out: got v=%b pc=%h instr=%h expected v=1 pc=fffffffc instr=2152fffc", if_valid, if_pc, if_instr); else passed++;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
      $display("FAIL wr_req_wrapped: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    tick();
    redirect_valid = 1'b0;
    tick(); tick(); tick();
    // Now waiting on 0x3004 with if_pc holding 0x3000; suppress its response.
    total++; if (if_pc !== 32'h3000) $display("FAIL ar_pre: got if_pc=%h expected 00003000", if_pc); else passed++;
    auto_mem = 1'b0; imem_rsp_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_req_valid !== 1'b0)
      $display("FAIL ar_async: got v=%b pc=%h instr=%h req=%b expected 0 00000000 00000000 0",
               if_valid, if_pc, if_instr, imem_req_valid); else passed++;
    tick();
    rst = 1'b0; imem_req_ready = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
      $display("FAIL ar_first_req: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr); else passed++;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    total++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
      $display("FAIL ar_stale_ignored: got if_valid=%b req=%b a=%h expected 0 1 00000000", if_valid, imem_req_valid, imem_req_addr); else passed++;
    imem_req_ready = 1'b1; auto_mem = 1'b1;
    tick(); tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hDEAD_0000)
      $display("FAIL ar_out: got v=%b pc=%h instr=%h expected v=1 pc=00000000 instr=dead0000", if_valid, if_pc, if_instr); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_flush();
    test_redirect_same_cycle();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch stage sitting directly downstream of the PC-select mux.
- Accepts the selected redirect target (branch/jump) or auto-increments by 4, and holds the architectural PC register.
- Issues one outstanding request at a time to instruction memory over a valid/ready request channel with a fixed response channel.
- Presents {pc, instr} to decode through a one-entry valid/ready output register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, PC/instruction width. Only 32 is supported.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Asynchronous, active-high reset.
- redirect_valid  in  1  Load redirect_pc as next fetch address (output of the PC-select mux path is valid).
- redirect_pc  in  32  Redirect target.
- imem_req_valid  out  1  Fetch request valid.
- imem_req_ready  in  1  Memory accepts request.
- imem_req_addr  out  32  Fetch address, word-aligned.
- imem_rsp_valid  in  1  Response data valid. There is no backpressure on this channel.
- imem_rsp_data  in  32  Fetched instruction.
- if_valid  out  1  {if_pc, if_instr} valid to decode.
- if_ready  in  1  Decode accepts.
- if_pc  out  32  PC of presented instruction.
- if_instr  out  32  Presented instruction.

Behaviour:
- Reset values:
  - pc = RESET_PC, state = REQ.
  - if_valid = 0, if_pc = 0, if_instr = 0.
  - imem_req_valid = 0 while rst is high.
  - Reset deasserting mid-transaction abandons everything; a late imem_rsp_valid in IDLE/REQ after reset is ignored.
- Registers:
  - pc (32).
  - state: REQ, WAIT, DROP.
  - Output register: if_valid, if_pc, if_instr.
- Output slot free (combinational): free = !if_valid || if_ready.
- REQ state:
  - imem_req_valid = free && !redirect_valid.
  - imem_req_addr = pc.
  - On imem_req_valid && imem_req_ready, go to WAIT.
- WAIT state:
  - imem_req_valid = 0.
  - On imem_rsp_valid: load if_pc <= pc, if_instr <= imem_rsp_data, if_valid <= 1; set pc <= pc + 4; go to REQ.
- DROP state:
  - imem_req_valid = 0.
  - On imem_rsp_valid, discard the data and go to REQ.
  - pc keeps its redirected value.
- Output handshake:
  - if_valid && if_ready clears if_valid, unless a new response loads it in the same cycle; then if_valid stays 1 with the new data.
  - Data is held stable while if_valid && !if_ready.
  - Issuing only when free guarantees a response never overwrites an unconsumed entry.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[31:2], 2'b00}; bits [1:0] are forced to zero.
  - if_valid <= 0, flushing the output register even if if_ready is high.
  - State transitions on redirect:
    - REQ without handshake: stay REQ.
    - WAIT: go to DROP; a response arriving that same cycle is discarded and the state goes to REQ.
    - DROP: stay DROP.
  - No request is issued in the redirect cycle.
- Arithmetic: pc + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Latency: redirect in cycle N gives an earliest request at N+1. With memory ready and a 1-cycle response, if_valid rises 2 cycles after the request is issued.
- Throughput: at most one instruction per 2 cycles (single outstanding request).

Test Plan:
- Reset release, imem ready always, 1-cycle response, if_ready=1 → requests to 0x0, 0x4, 0x8; if_pc/if_instr match the returned data in order; no gaps beyond 2 cycles per instruction.
- if_ready=0 for 5 cycles after the first instruction → if_pc=0x0 stays stable and imem_req_valid=0 throughout; after if_ready=1, the request to 0x4 is issued the next cycle.
- Redirect to 0x1003 while in WAIT → output flushed; the response for the old PC is discarded, not presented; the next request address is 0x1000; if_pc=0x1000.
- Redirect in the same cycle as imem_rsp_valid in WAIT → data discarded, if_valid=0; next cycle a request to the redirect target.
- Redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC, then 0x0000_0000.
- Assert rst asynchronously mid-WAIT with a response arriving 1 cycle after release → if_valid=0, pc=RESET_PC, stale response ignored, first request to RESET_PC.
